// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the rasterizer triangle-setup slice.
// Vertex layout, setup FSM states and small signed helpers.
package rasterizer_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_FIN, S_OUT} setup_state_e;

    localparam int VX      = 0;
    localparam int VY      = 1;
    localparam int VZ      = 2;
    localparam int VC      = 3;
    localparam int VSTRIDE = 5;
    localparam int NVERT   = 3;
    localparam int NWORDS  = NVERT * VSTRIDE;
    localparam int CW      = 40;
    localparam int TRI_W   = NWORDS * 32;

    typedef logic [NWORDS-1:0][31:0] tri_words_t;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [15:0] clamp16(input logic signed [15:0] v, hi);
        if (v < 16'sd0) return 16'sd0;
        if (v > hi)     return hi;
        return v;
    endfunction

endpackage

// File: rtl/rasterizer_triangle_setup_if.sv
// Triangle-in / setup-record-out bus. master is the setup unit itself;
// slave is its surroundings (vertex fetch upstream, traversal downstream).
interface rasterizer_triangle_setup_if;
    import rasterizer_pkg::*;

    logic                        in_valid;
    tri_words_t                  vertex_in;
    logic                        stall_out;
    logic                        out_valid;
    logic                        stall_in;
    logic [NVERT-1:0][31:0]      edge_a;
    logic [NVERT-1:0][31:0]      edge_b;
    logic [NVERT-1:0][CW-1:0]    edge_c;
    logic [CW-1:0]               area2;
    logic [15:0]                 bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y;
    logic [NVERT-1:0][31:0]      z_out;
    logic [NVERT-1:0][31:0]      color_out;

    modport master (
        input  in_valid, vertex_in, stall_in,
        output stall_out, out_valid, edge_a, edge_b, edge_c, area2,
               bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y, z_out, color_out
    );
    modport slave (
        output in_valid, vertex_in, stall_in,
        input  stall_out, out_valid, edge_a, edge_b, edge_c, area2,
               bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y, z_out, color_out
    );
endinterface

// File: rtl/rasterizer_setup_skid.sv
// Small circular FIFO holding whole triangles between fetch and setup.
// Pushes into a full buffer are ignored; the parent flags the overflow.
module rasterizer_setup_skid #(
    parameter  int DEPTH = 2,
    parameter  int W     = 480,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= nxt(wr_ptr);
            if (pop_ok)  rd_ptr <= nxt(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/rasterizer_triangle_setup.sv
// Triangle setup: edge coefficients, doubled area and clamped bbox per triangle,
// using one shared 16x16 multiplier over six cycles; culls before handing off.
module rasterizer_triangle_setup
    import rasterizer_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter bit CULL_BACK  = 1'b0,
    parameter int SKID_DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    rasterizer_triangle_setup_if.master  bus,
    input  logic                         done_in,
    output logic                         done_out,
    output logic [31:0]                  tri_in_count,
    output logic [31:0]                  tri_cull_count,
    output logic                         overflow_err
);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic signed [15:0] XMAX = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] YMAX = 16'(SCREEN_H - 1);

    setup_state_e        state, state_nx;
    logic [CNT_W-1:0]    skid_count;
    logic                skid_full, skid_pop;
    tri_words_t          head;
    logic                head_unused;
    logic [2:0]          k;

    logic signed [15:0]  hx [NVERT], hy [NVERT];
    logic signed [15:0]  vx [NVERT], vy [NVERT];
    logic signed [31:0]  a_r [NVERT], b_r [NVERT];
    logic signed [CW-1:0] c_r [NVERT];
    logic signed [CW-1:0] area_r, area_sum;
    logic signed [15:0]  mnx, mny, mxx, mxy;
    logic [NVERT-1:0][31:0] z_r, col_r;
    logic signed [15:0]  ma, mb;
    logic signed [31:0]  prod, p_hold;
    logic                neg, off_screen, drop;
    logic                stall_q, done_q;

    rasterizer_setup_skid #(.DEPTH(SKID_DEPTH), .W(TRI_W)) u_skid (
        .clock (clock),
        .reset (reset),
        .push  (bus.in_valid),
        .din   (bus.vertex_in),
        .pop   (skid_pop),
        .dout  (head),
        .count (skid_count),
        .full  (skid_full)
    );

    // Only the low 16 bits of x/y matter; upper bits and the reserved word are dropped here.
    always_comb begin
        head_unused = 1'b0;
        for (int i = 0; i < NVERT; i++) begin
            hx[i] = head[VSTRIDE*i+VX][15:0];
            hy[i] = head[VSTRIDE*i+VY][15:0];
            head_unused ^= ^{head[VSTRIDE*i+VX][31:16], head[VSTRIDE*i+VY][31:16],
                             head[VSTRIDE*i+VSTRIDE-1]};
        end
    end

    // Product order pairs up so that odd steps close one C term: p0-p1, p2-p3, p4-p5.
    always_comb begin
        ma = vx[0]; mb = vy[1];
        case (k)
            3'd1: begin ma = vx[1]; mb = vy[0]; end
            3'd2: begin ma = vx[1]; mb = vy[2]; end
            3'd3: begin ma = vx[2]; mb = vy[1]; end
            3'd4: begin ma = vx[2]; mb = vy[0]; end
            3'd5: begin ma = vx[0]; mb = vy[2]; end
            default: ;
        endcase
        prod = 32'(ma) * 32'(mb);
    end

    always_comb begin
        area_sum   = c_r[0] + c_r[1] + c_r[2];
        neg        = area_sum[CW-1];
        off_screen = (mxx < 16'sd0) || (mnx > XMAX) || (mxy < 16'sd0) || (mny > YMAX);
        drop       = (area_sum == '0) || off_screen || (neg && CULL_BACK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (skid_count != '0) state_nx = S_LOAD;
            S_LOAD: state_nx = S_MUL;
            S_MUL:  if (k == 3'd5) state_nx = S_FIN;
            S_FIN:  state_nx = drop ? S_IDLE : S_OUT;
            S_OUT:  if (!bus.stall_in) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        skid_pop      = (state == S_LOAD);
        bus.out_valid = (state == S_OUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NVERT; i++) begin
                vx[i] <= '0; vy[i] <= '0; a_r[i] <= '0; b_r[i] <= '0; c_r[i] <= '0;
            end
            z_r <= '0; col_r <= '0; area_r <= '0; p_hold <= '0; k <= '0;
            mnx <= '0; mny <= '0; mxx <= '0; mxy <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    for (int i = 0; i < NVERT; i++) begin
                        vx[i]    <= hx[i];
                        vy[i]    <= hy[i];
                        z_r[i]   <= head[VSTRIDE*i+VZ];
                        col_r[i] <= head[VSTRIDE*i+VC];
                        a_r[i]   <= 32'(hy[i]) - 32'(hy[(i+1)%NVERT]);
                        b_r[i]   <= 32'(hx[(i+1)%NVERT]) - 32'(hx[i]);
                    end
                    mnx <= min3(hx[0], hx[1], hx[2]);
                    mxx <= max3(hx[0], hx[1], hx[2]);
                    mny <= min3(hy[0], hy[1], hy[2]);
                    mxy <= max3(hy[0], hy[1], hy[2]);
                    k   <= '0;
                end
                S_MUL: begin
                    if (!k[0]) p_hold <= prod;
                    else       c_r[k[2:1]] <= CW'(p_hold) - CW'(prod);
                    k <= k + 3'd1;
                end
                S_FIN: begin
                    // Clockwise triangles are flipped so traversal only ever sees positive winding.
                    area_r <= neg ? -area_sum : area_sum;
                    if (neg) begin
                        for (int i = 0; i < NVERT; i++) begin
                            a_r[i] <= -a_r[i]; b_r[i] <= -b_r[i]; c_r[i] <= -c_r[i];
                        end
                    end
                    mnx <= clamp16(mnx, XMAX);
                    mxx <= clamp16(mxx, XMAX);
                    mny <= clamp16(mny, YMAX);
                    mxy <= clamp16(mxy, YMAX);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tri_in_count   <= '0;
            tri_cull_count <= '0;
            overflow_err   <= 1'b0;
            stall_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            if (bus.in_valid && !skid_full) tri_in_count <= tri_in_count + 32'd1;
            if (bus.in_valid && skid_full)  overflow_err <= 1'b1;
            if (state == S_FIN && drop)     tri_cull_count <= tri_cull_count + 32'd1;
            stall_q <= (skid_count != '0) || (state != S_IDLE);
            done_q  <= done_in && (state == S_IDLE) && (skid_count == '0) && !bus.in_valid;
        end
    end

    assign bus.stall_out  = stall_q;
    assign done_out       = done_q;
    assign bus.edge_a     = {a_r[2], a_r[1], a_r[0]};
    assign bus.edge_b     = {b_r[2], b_r[1], b_r[0]};
    assign bus.edge_c     = {c_r[2], c_r[1], c_r[0]};
    assign bus.area2      = area_r;
    assign bus.bbox_min_x = mnx;
    assign bus.bbox_min_y = mny;
    assign bus.bbox_max_x = mxx;
    assign bus.bbox_max_y = mxy;
    assign bus.z_out      = z_r;
    assign bus.color_out  = col_r;
endmodule

// File: tb/tb_rasterizer_triangle_setup.sv
// Directed bench for rasterizer_triangle_setup: a reference model queues expected
// setup records as triangles are sent; records are popped and compared on output.
module tb_rasterizer_triangle_setup;
    import rasterizer_pkg::*;

    localparam int SW = 640;
    localparam int SH = 480;

    typedef struct packed {
        logic [2:0][31:0] a, b;
        logic [2:0][39:0] c;
        logic [39:0]      area;
        logic [15:0]      mnx, mny, mxx, mxy;
        logic [2:0][31:0] z, col;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic done_in = 1'b0;
    logic done_out0, done_out1, ovf0, ovf1;
    logic [31:0] in_cnt0, cull_cnt0, in_cnt1, cull_cnt1;

    rec_t exp_q[$];
    int   vectors = 0, miscompares = 0;
    int   exp_in = 0, exp_cull = 0, seq = 0;
    bit   seen1 = 1'b0;

    always #5 clock = ~clock;

    rasterizer_triangle_setup_if bus0();
    rasterizer_triangle_setup_if bus1();

    rasterizer_triangle_setup #(.SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(1'b0), .SKID_DEPTH(2)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .done_in(done_in), .done_out(done_out0),
        .tri_in_count(in_cnt0), .tri_cull_count(cull_cnt0), .overflow_err(ovf0));

    rasterizer_triangle_setup #(.SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(1'b1), .SKID_DEPTH(2)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .done_in(done_in), .done_out(done_out1),
        .tri_in_count(in_cnt1), .tri_cull_count(cull_cnt1), .overflow_err(ovf1));

    always @(posedge clock) if (bus1.out_valid) seen1 <= 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic bit model(input logic [2:0][15:0] xs, ys, input tri_words_t v,
                                 input bit cull, output rec_t r);
        longint X[3], Y[3], A[3], B[3], C[3];
        longint area, mnx, mxx, mny, mxy;
        bit emit;
        for (int i = 0; i < 3; i++) begin
            X[i] = longint'($signed(xs[i]));
            Y[i] = longint'($signed(ys[i]));
        end
        area = 0;
        for (int i = 0; i < 3; i++) begin
            int j;
            j = (i + 1) % 3;
            A[i] = Y[i] - Y[j];
            B[i] = X[j] - X[i];
            C[i] = X[i] * Y[j] - X[j] * Y[i];
            area += C[i];
        end
        mnx = X[0]; mxx = X[0]; mny = Y[0]; mxy = Y[0];
        for (int i = 1; i < 3; i++) begin
            if (X[i] < mnx) mnx = X[i];
            if (X[i] > mxx) mxx = X[i];
            if (Y[i] < mny) mny = Y[i];
            if (Y[i] > mxy) mxy = Y[i];
        end
        emit = (area != 0) && !(mxx < 0 || mnx > SW-1 || mxy < 0 || mny > SH-1) && !(area < 0 && cull);
        if (area < 0) begin
            area = -area;
            for (int i = 0; i < 3; i++) begin A[i] = -A[i]; B[i] = -B[i]; C[i] = -C[i]; end
        end
        mnx = (mnx < 0) ? 0 : (mnx > SW-1) ? SW-1 : mnx;
        mxx = (mxx < 0) ? 0 : (mxx > SW-1) ? SW-1 : mxx;
        mny = (mny < 0) ? 0 : (mny > SH-1) ? SH-1 : mny;
        mxy = (mxy < 0) ? 0 : (mxy > SH-1) ? SH-1 : mxy;
        for (int i = 0; i < 3; i++) begin
            r.a[i]   = 32'(A[i]);
            r.b[i]   = 32'(B[i]);
            r.c[i]   = 40'(C[i]);
            r.z[i]   = v[5*i+2];
            r.col[i] = v[5*i+3];
        end
        r.area = 40'(area);
        r.mnx = 16'(mnx); r.mxx = 16'(mxx); r.mny = 16'(mny); r.mxy = 16'(mxy);
        return emit;
    endfunction

    // Drives one in_valid pulse; garbage in the ignored upper/reserved bits on purpose.
    task automatic send(input int x0, y0, x1, y1, x2, y2, input bit ovf, input bit both);
        tri_words_t v;
        logic [2:0][15:0] xs, ys;
        rec_t r;
        xs = {16'(x2), 16'(x1), 16'(x0)};
        ys = {16'(y2), 16'(y1), 16'(y0)};
        seq++;
        for (int i = 0; i < 3; i++) begin
            v[5*i+0] = {16'hA5A5 ^ 16'(seq), xs[i]};
            v[5*i+1] = {16'h5A5A, ys[i]};
            v[5*i+2] = 32'h2000_0000 + 32'(seq * 16 + i);
            v[5*i+3] = 32'hC000_0000 | 32'(seq * 16 + i);
            v[5*i+4] = 32'hDEAD_BEEF;
        end
        if (!ovf) begin
            exp_in++;
            if (model(xs, ys, v, 1'b0, r)) exp_q.push_back(r);
            else                           exp_cull++;
        end
        bus0.vertex_in = v;
        bus0.in_valid  = 1'b1;
        if (both) begin
            bus1.vertex_in = v;
            bus1.in_valid  = 1'b1;
        end
        tick();
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    // Waits (bounded) for a record on dut0, compares it with the queue head, then lets it transfer.
    task automatic expect_rec(input string tag);
        rec_t e;
        int n;
        n = 0;
        while (!bus0.out_valid && n < 40) begin tick(); n++; end
        chk({tag, "_valid"}, 128'(bus0.out_valid), 128'(1));
        chk({tag, "_queued"}, 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_a"},    128'(bus0.edge_a), 128'(e.a));
            chk({tag, "_b"},    128'(bus0.edge_b), 128'(e.b));
            chk({tag, "_c"},    128'(bus0.edge_c), 128'(e.c));
            chk({tag, "_area"}, 128'(bus0.area2),  128'(e.area));
            chk({tag, "_bbox"}, 128'({bus0.bbox_min_x, bus0.bbox_min_y, bus0.bbox_max_x, bus0.bbox_max_y}),
                                128'({e.mnx, e.mny, e.mxx, e.mxy}));
            chk({tag, "_z"},    128'(bus0.z_out),     128'(e.z));
            chk({tag, "_col"},  128'(bus0.color_out), 128'(e.col));
        end
        tick();
    endtask

    logic [2:0][31:0] ea, eb;
    logic [2:0][39:0] ec, snap_c;
    logic [39:0]      snap_area;
    logic [63:0]      snap_bb;
    int               n;

    initial begin
        bus0.in_valid = 1'b0; bus0.vertex_in = '0; bus0.stall_in = 1'b0;
        bus1.in_valid = 1'b0; bus1.vertex_in = '0; bus1.stall_in = 1'b0;
        ticks(3);
        chk("rst_out_valid", 128'(bus0.out_valid), 128'(0));
        chk("rst_stall_out", 128'(bus0.stall_out), 128'(0));
        chk("rst_in_cnt",    128'(in_cnt0),        128'(0));
        chk("rst_cull_cnt",  128'(cull_cnt0),      128'(0));
        chk("rst_ovf",       128'(ovf0),           128'(0));
        chk("rst_done",      128'(done_out0),      128'(0));
        chk("rst_area",      128'(bus0.area2),     128'(0));
        reset = 1'b1;
        tick();

        // Basic CCW triangle and its latency.
        send(0, 0, 10, 0, 0, 10, 1'b0, 1'b0);
        ticks(8);
        chk("lat_8", 128'(bus0.out_valid), 128'(0));
        tick();
        chk("lat_9", 128'(bus0.out_valid), 128'(1));
        ea[0] = 32'd0;  ea[1] = -32'sd10; ea[2] = 32'd10;
        eb[0] = 32'd10; eb[1] = -32'sd10; eb[2] = 32'd0;
        ec[0] = 40'd0;  ec[1] = 40'd100;  ec[2] = 40'd0;
        chk("t1_const_a", 128'(bus0.edge_a), 128'(ea));
        chk("t1_const_b", 128'(bus0.edge_b), 128'(eb));
        chk("t1_const_c", 128'(bus0.edge_c), 128'(ec));
        chk("t1_const_area", 128'(bus0.area2), 128'(40'd100));
        chk("t1_const_bbox", 128'({bus0.bbox_min_x, bus0.bbox_min_y, bus0.bbox_max_x, bus0.bbox_max_y}),
                             128'({16'd0, 16'd0, 16'd10, 16'd10}));
        chk("t1_in_cnt", 128'(in_cnt0), 128'(exp_in));
        expect_rec("t1");

        // Same triangle with reversed winding: flipped on dut0, culled on dut1.
        send(0, 0, 0, 10, 10, 0, 1'b0, 1'b1);
        expect_rec("t2");
        chk("t2_area_pos", 128'(bus0.area2), 128'(40'd100));
        ticks(3);
        chk("t2_cull1_cnt", 128'(cull_cnt1), 128'(1));
        chk("t2_cull1_novalid", 128'(seen1), 128'(0));

        // Degenerate and fully off-screen triangles.
        send(0, 0, 5, 5, 10, 10, 1'b0, 1'b0);
        ticks(12);
        send(700, 0, 710, 0, 700, 10, 1'b0, 1'b0);
        ticks(12);
        chk("cull_cnt", 128'(cull_cnt0), 128'(exp_cull));
        chk("cull_idle_stall", 128'(bus0.stall_out), 128'(0));
        chk("cull_no_queue", 128'(exp_q.size()), 128'(0));

        // Bounding box clamping on both axes.
        send(-20, 100, 30, 900, 0, 500, 1'b0, 1'b0);
        expect_rec("t4");
        chk("t4_clamp", 128'({bus0.bbox_min_x, bus0.bbox_min_y, bus0.bbox_max_x, bus0.bbox_max_y}),
                        128'({16'd0, 16'd100, 16'd30, 16'd479}));

        // Backpressure, skid fill, overflow and done_out gating.
        bus0.stall_in = 1'b1;
        done_in = 1'b1;
        send(0, 0, 20, 0, 0, 20, 1'b0, 1'b0);
        n = 0;
        while (!bus0.out_valid && n < 40) begin tick(); n++; end
        chk("bp_valid", 128'(bus0.out_valid), 128'(1));
        chk("bp_stall_out", 128'(bus0.stall_out), 128'(1));
        snap_area = bus0.area2;
        snap_c    = bus0.edge_c;
        snap_bb   = {bus0.bbox_min_x, bus0.bbox_min_y, bus0.bbox_max_x, bus0.bbox_max_y};
        send(1, 1, 15, 2, 3, 17, 1'b0, 1'b0);
        send(5, 5, 40, 5, 5, 40, 1'b0, 1'b0);
        chk("bp_no_ovf", 128'(ovf0), 128'(0));
        send(2, 2, 9, 2, 2, 9, 1'b1, 1'b0);
        chk("bp_ovf", 128'(ovf0), 128'(1));
        chk("bp_in_cnt", 128'(in_cnt0), 128'(exp_in));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 128'(bus0.out_valid), 128'(1));
            chk("bp_hold_area",  128'(bus0.area2), 128'(snap_area));
            chk("bp_hold_c",     128'(bus0.edge_c), 128'(snap_c));
            chk("bp_hold_bbox",  128'({bus0.bbox_min_x, bus0.bbox_min_y, bus0.bbox_max_x, bus0.bbox_max_y}),
                                 128'(snap_bb));
            chk("bp_done_busy",  128'(done_out0), 128'(0));
        end
        bus0.stall_in = 1'b0;
        expect_rec("ta");
        expect_rec("tb");
        chk("done_pending", 128'(done_out0), 128'(0));
        expect_rec("tc");
        n = 0;
        while (!done_out0 && n < 5) begin tick(); n++; end
        chk("done_rise", 128'(done_out0), 128'(1));
        done_in = 1'b0;
        tick();
        chk("done_fall", 128'(done_out0), 128'(0));

        // Reset while the multiplier is busy.
        send(0, 0, 10, 0, 0, 10, 1'b0, 1'b0);
        ticks(4);
        reset = 1'b0;
        #1;
        chk("mrst_valid",    128'(bus0.out_valid), 128'(0));
        chk("mrst_in_cnt",   128'(in_cnt0),        128'(0));
        chk("mrst_cull_cnt", 128'(cull_cnt0),      128'(0));
        chk("mrst_ovf",      128'(ovf0),           128'(0));
        chk("mrst_stall",    128'(bus0.stall_out), 128'(0));
        exp_q.delete();
        tick();
        reset = 1'b1;
        ticks(3);
        chk("mrst_empty_stall", 128'(bus0.stall_out), 128'(0));
        chk("mrst_empty_valid", 128'(bus0.out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
